// File: rtl/wishbone_arbiter_if.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter_if
// Groups the request/grant/response wiring between N_MASTER Wishbone masters,
// the shared slave side and the round-robin arbiter.
//   m_cyc_i / m_stb_i / m_lock_i : per-master cyc, stb, lock (requests)
//   m_gnt_o                      : one-hot grant to each master
//   m_ack_o / m_err_o / m_rty_o  : responses routed to the owning master
//   s_cyc_o / s_stb_o            : cyc/stb toward the slave
//   s_ack_i / s_err_i / s_rty_i  : slave responses
//   gnt_idx_o / gnt_valid_o      : owner index for the adr/dat mux, owner valid
//   timeout_o                    : watchdog fire pulse
// Modports: slave  = the arbiter's view
//           master = the surrounding masters/slave (or bench) view
// -----------------------------------------------------------------------------
interface wishbone_arbiter_if #(
   parameter int N_MASTER = 4
);
   localparam int IDX_W = $clog2(N_MASTER);

   logic [N_MASTER-1:0] m_cyc_i;
   logic [N_MASTER-1:0] m_stb_i;
   logic [N_MASTER-1:0] m_lock_i;
   logic [N_MASTER-1:0] m_gnt_o;
   logic [N_MASTER-1:0] m_ack_o;
   logic [N_MASTER-1:0] m_err_o;
   logic [N_MASTER-1:0] m_rty_o;
   logic                s_cyc_o;
   logic                s_stb_o;
   logic                s_ack_i;
   logic                s_err_i;
   logic                s_rty_i;
   logic [IDX_W-1:0]    gnt_idx_o;
   logic                gnt_valid_o;
   logic                timeout_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_lock_i, s_ack_i, s_err_i, s_rty_i,
      output m_gnt_o, m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o,
             gnt_idx_o, gnt_valid_o, timeout_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_lock_i, s_ack_i, s_err_i, s_rty_i,
      input  m_gnt_o, m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o,
             gnt_idx_o, gnt_valid_o, timeout_o
   );
endinterface

// File: rtl/wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter
// Round-robin arbiter sharing one Wishbone slave bus between N_MASTER masters,
// with lock support and a bus watchdog that ends hung transfers with an err.
// Ports:
//   clk_i   : clock
//   rstn_i  : asynchronous active-low reset
//   bus     : wishbone_arbiter_if.slave (requests in, grants/responses out)
// Grant, owner index and owner-valid are registered; cyc/stb toward the slave,
// routed responses and timeout_o are combinational on the current owner.
// -----------------------------------------------------------------------------
module wishbone_arbiter #(
   parameter int N_MASTER = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   wishbone_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(N_MASTER);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_MASTER - 1);
   localparam logic [N_MASTER-1:0] ONE      = N_MASTER'(1);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t              state_q;
   logic [N_MASTER-1:0] gnt_q;
   logic [IDX_W-1:0]    gnt_idx_q;
   logic                gnt_valid_q;
   logic [IDX_W-1:0]    prio_q;
   logic [CNT_W-1:0]    wdog_q;

   logic [IDX_W-1:0]    pick;
   logic [IDX_W-1:0]    cand;
   logic                pick_ok;
   logic                own_cyc;
   logic                own_stb;
   logic                own_lock;
   logic                busy;
   logic                resp;
   logic                stalled;
   logic                fire;
   logic [IDX_W-1:0]    prio_next;

   assign own_cyc  = bus.m_cyc_i[gnt_idx_q];
   assign own_stb  = bus.m_stb_i[gnt_idx_q];
   assign own_lock = bus.m_lock_i[gnt_idx_q];
   assign busy     = (state_q == BUSY);
   assign resp     = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
   assign stalled  = busy & own_stb & ~resp;
   // The counter holds the stalled cycles already seen, so the watchdog fires
   // on the cycle that would make it reach TIMEOUT; a response that cycle wins.
   assign fire     = stalled & (wdog_q == CNT_LAST);
   assign prio_next = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;

   // Search from prio_q upward with wrap; iterating downward in offset lets the
   // lowest offset (highest priority) overwrite any later match.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      cand    = '0;
      for (int i = N_MASTER - 1; i >= 0; i--) begin
         cand = IDX_W'((int'(prio_q) + i) % N_MASTER);
         if (bus.m_cyc_i[cand]) begin
            pick    = cand;
            pick_ok = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         prio_q      <= '0;
         wdog_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               wdog_q <= '0;
               if (pick_ok) begin
                  state_q     <= BUSY;
                  gnt_idx_q   <= pick;
                  gnt_q       <= ONE << pick;
                  gnt_valid_q <= 1'b1;
               end
            end
            BUSY: begin
               if (!own_cyc) begin
                  wdog_q <= '0;
                  if (own_lock) begin
                     state_q <= HOLD;
                  end else begin
                     state_q     <= IDLE;
                     gnt_q       <= '0;
                     gnt_valid_q <= 1'b0;
                     prio_q      <= prio_next;
                  end
               end else if (stalled && !fire) begin
                  wdog_q <= wdog_q + 1'b1;
               end else begin
                  wdog_q <= '0;
               end
            end
            HOLD: begin
               wdog_q <= '0;
               if (own_cyc) begin
                  state_q <= BUSY;
               end else if (!own_lock) begin
                  state_q     <= IDLE;
                  gnt_q       <= '0;
                  gnt_valid_q <= 1'b0;
                  prio_q      <= prio_next;
               end
            end
            default: begin
               state_q     <= IDLE;
               gnt_q       <= '0;
               gnt_valid_q <= 1'b0;
               wdog_q      <= '0;
            end
         endcase
      end
   end

   assign bus.m_gnt_o     = gnt_q;
   assign bus.gnt_idx_o   = gnt_idx_q;
   assign bus.gnt_valid_o = gnt_valid_q;
   assign bus.s_cyc_o     = busy & own_cyc;
   assign bus.s_stb_o     = busy & own_stb;
   // gnt_q is zero whenever nobody owns the bus, so masking routes responses
   // to the owner only and silences everything else.
   assign bus.m_ack_o     = gnt_q & {N_MASTER{bus.s_ack_i}};
   assign bus.m_err_o     = gnt_q & {N_MASTER{bus.s_err_i | fire}};
   assign bus.m_rty_o     = gnt_q & {N_MASTER{bus.s_rty_i}};
   assign bus.timeout_o   = fire;

endmodule

// File: tb/tb_wishbone_arbiter.sv
module tb_wishbone_arbiter;
   localparam int N  = 4;
   localparam int TO = 8;
   localparam logic [N-1:0] ONE = N'(1);

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   wishbone_arbiter_if #(.N_MASTER(N)) bus ();

   wishbone_arbiter #(.N_MASTER(N), .TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rstn_i(rstn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic bitof(input logic [N-1:0] v, input int k);
      logic [N-1:0] t;
      t = v >> k;
      return t[0];
   endfunction

   // Behavioural model: who owns the bus, whether the owner is parked on lock,
   // the rotating start point and the number of consecutive stalled cycles.
   int m_owner = -1, m_prio = 0, m_stall = 0;
   bit m_hold  = 1'b0;
   int n_owner = -1, n_prio = 0, n_stall = 0;
   bit n_hold  = 1'b0;

   logic [N-1:0] e_gnt;
   logic act, o_cyc, o_stb, rsp, fire, found;
   int   cand;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_owner = -1; m_prio = 0; m_stall = 0; m_hold = 1'b0;
      end else begin
         m_owner = n_owner; m_prio = n_prio; m_stall = n_stall; m_hold = n_hold;
      end
   end

   always @(negedge clk) begin
      if (!rstn) begin
         n_owner = -1; n_prio = 0; n_stall = 0; n_hold = 1'b0;
      end else begin
         e_gnt = (m_owner >= 0) ? (ONE << m_owner) : '0;
         act   = (m_owner >= 0) && !m_hold;
         o_cyc = act && bitof(bus.m_cyc_i, m_owner);
         o_stb = act && bitof(bus.m_stb_i, m_owner);
         rsp   = bus.s_ack_i || bus.s_err_i || bus.s_rty_i;
         fire  = o_stb && !rsp && (m_stall == TO - 1);
         chk("gnt", 32'(bus.m_gnt_o), 32'(e_gnt));
         chk("gnt_valid", 32'(bus.gnt_valid_o), 32'(m_owner >= 0));
         if (m_owner >= 0) chk("gnt_idx", 32'(bus.gnt_idx_o), m_owner);
         chk("s_cyc", 32'(bus.s_cyc_o), 32'(o_cyc));
         chk("s_stb", 32'(bus.s_stb_o), 32'(o_stb));
         chk("m_ack", 32'(bus.m_ack_o), bus.s_ack_i ? 32'(e_gnt) : 0);
         chk("m_err", 32'(bus.m_err_o), (bus.s_err_i || fire) ? 32'(e_gnt) : 0);
         chk("m_rty", 32'(bus.m_rty_o), bus.s_rty_i ? 32'(e_gnt) : 0);
         chk("timeout", 32'(bus.timeout_o), 32'(fire));

         n_owner = m_owner; n_prio = m_prio; n_hold = m_hold; n_stall = 0;
         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               cand = (m_prio + k) % N;
               if (!found && bitof(bus.m_cyc_i, cand)) begin
                  found = 1'b1;
                  n_owner = cand;
                  n_hold  = 1'b0;
               end
            end
         end else if (!bitof(bus.m_cyc_i, m_owner)) begin
            if (bitof(bus.m_lock_i, m_owner)) begin
               n_hold = 1'b1;
            end else begin
               n_owner = -1;
               n_hold  = 1'b0;
               n_prio  = (m_owner + 1) % N;
            end
         end else if (m_hold) begin
            n_hold = 1'b0;
         end else if (o_stb && !rsp && !fire) begin
            n_stall = m_stall + 1;
         end
      end
   end

   task automatic clear_inputs();
      bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_lock_i = '0;
      bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rstn = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   int pr;

   initial begin
      clear_inputs();
      bus.m_cyc_i = 4'b1111;
      #2;
      chk("rst_gnt", 32'(bus.m_gnt_o), 0);
      chk("rst_valid", 32'(bus.gnt_valid_o), 0);
      chk("rst_idx", 32'(bus.gnt_idx_o), 0);
      chk("rst_timeout", 32'(bus.timeout_o), 0);
      chk("rst_scyc", 32'(bus.s_cyc_o), 0);
      repeat (2) @(posedge clk);
      #1;
      clear_inputs();
      rstn = 1'b1;

      // Single request
      bus.m_cyc_i = 4'b0001;
      #1 chk("single_no_same_cycle", 32'(bus.m_gnt_o), 0);
      step();
      chk("single_gnt", 32'(bus.m_gnt_o), 32'h1);
      chk("single_idx", 32'(bus.gnt_idx_o), 0);
      bus.m_stb_i = 4'b0001; bus.s_ack_i = 1'b1;
      #1 chk("single_ack", 32'(bus.m_ack_o), 32'h1);
      step();
      bus.s_ack_i = 1'b0; bus.m_stb_i = '0; bus.m_cyc_i = '0;
      #1 chk("single_drop_cycle", 32'(bus.m_gnt_o), 32'h1);
      step();
      chk("single_released", 32'(bus.m_gnt_o), 0);

      // Round robin with all masters requesting
      do_reset();
      bus.m_cyc_i = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         step();
         chk("rr_idx", 32'(bus.gnt_idx_o), r % 4);
         chk("rr_gnt", 32'(bus.m_gnt_o), 32'(ONE << (r % 4)));
         bus.m_stb_i = ONE << (r % 4); bus.s_ack_i = 1'b1;
         step();
         bus.s_ack_i = 1'b0; bus.m_stb_i = '0;
         bus.m_cyc_i = 4'b1111 & ~(ONE << (r % 4));
         step();
         chk("rr_idle_gap", 32'(bus.m_gnt_o), 0);
         bus.m_cyc_i = 4'b1111;
      end

      // Lock hold
      do_reset();
      bus.m_cyc_i = 4'b0100; bus.m_lock_i = 4'b0100;
      step();
      chk("lock_gnt", 32'(bus.m_gnt_o), 32'h4);
      bus.m_cyc_i = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         #1 chk("lock_hold_gnt", 32'(bus.m_gnt_o), 32'h4);
         chk("lock_hold_scyc", 32'(bus.s_cyc_o), 0);
         step();
      end
      bus.m_lock_i = '0;
      #1 chk("lock_release_cycle", 32'(bus.m_gnt_o), 32'h4);
      step();
      chk("lock_idle", 32'(bus.m_gnt_o), 0);
      step();
      chk("lock_next_owner", 32'(bus.m_gnt_o), 32'h1);

      // Watchdog
      do_reset();
      bus.m_cyc_i = 4'b0010;
      step();
      bus.m_stb_i = 4'b0010;
      for (int k = 1; k <= 16; k++) begin
         #1 chk("wd_timeout", 32'(bus.timeout_o), 32'((k % 8) == 0));
         chk("wd_err", 32'(bus.m_err_o), ((k % 8) == 0) ? 32'h2 : 0);
         step();
      end

      // Response on the watchdog cycle
      do_reset();
      bus.m_cyc_i = 4'b0010;
      step();
      bus.m_stb_i = 4'b0010;
      repeat (7) step();
      bus.s_ack_i = 1'b1;
      #1 chk("race_ack", 32'(bus.m_ack_o), 32'h2);
      chk("race_err", 32'(bus.m_err_o), 0);
      chk("race_timeout", 32'(bus.timeout_o), 0);
      step();
      bus.s_ack_i = 1'b0;

      // Asynchronous reset mid-transfer
      do_reset();
      bus.m_cyc_i = 4'b0001;
      step();
      bus.m_stb_i = 4'b0001; bus.s_ack_i = 1'b1;
      #1 rstn = 1'b0;
      #1;
      chk("arst_gnt", 32'(bus.m_gnt_o), 0);
      chk("arst_valid", 32'(bus.gnt_valid_o), 0);
      chk("arst_scyc", 32'(bus.s_cyc_o), 0);
      chk("arst_ack", 32'(bus.m_ack_o), 0);
      bus.m_cyc_i = 4'b1000; bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
      step();
      rstn = 1'b1;
      step();
      chk("arst_regrant", 32'(bus.m_gnt_o), 32'h8);
      chk("arst_regrant_idx", 32'(bus.gnt_idx_o), 3);

      // Randomized traffic: busy slave phase, then a mostly silent slave
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         pr = (c < 1500) ? 30 : 3;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(15) == 0) bus.m_cyc_i[i] = ~bus.m_cyc_i[i];
            if ($urandom_range(7) == 0) bus.m_lock_i[i] = ~bus.m_lock_i[i];
            bus.m_stb_i[i] = bus.m_cyc_i[i] && ($urandom_range(3) != 0);
         end
         bus.s_ack_i = ($urandom_range(99) < pr);
         bus.s_err_i = ($urandom_range(99) < pr / 3);
         bus.s_rty_i = ($urandom_range(99) < pr / 3);
         if (c == 2200) begin
            #2 rstn = 1'b0;
            #1 chk("rand_arst_gnt", 32'(bus.m_gnt_o), 0);
            step();
            rstn = 1'b1;
         end else begin
            step();
         end
      end

      clear_inputs();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
